// File: rtl/cp0_io_subsystem_pkg.sv
// Shared encodings for the CP0 / IO bridge slice: exception codes, bus and CP0 op
// encodings, CP0 register numbers and the timer register map / FSM states.
package cp0_io_subsystem_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [1:0] CP0_NONE = 2'd0;
    localparam logic [1:0] CP0_MFC0 = 2'd1;
    localparam logic [1:0] CP0_MTC0 = 2'd2;
    localparam logic [1:0] CP0_ERET = 2'd3;

    localparam logic [1:0] MT_WORD = 2'd0;
    localparam logic [1:0] MT_HALF = 2'd1;
    localparam logic [1:0] MT_BYTE = 2'd2;

    localparam logic [1:0] MM_NONE  = 2'd0;
    localparam logic [1:0] MM_READ  = 2'd1;
    localparam logic [1:0] MM_WRITE = 2'd2;

    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;
    localparam logic [31:0] PRID_VALUE   = 32'h0000_0007;

    // Timer register word index (byte offset >> 2) and decoded window size.
    localparam logic [1:0]  TMR_CTRL   = 2'd0;
    localparam logic [1:0]  TMR_PRESET = 2'd1;
    localparam logic [1:0]  TMR_COUNT  = 2'd2;
    localparam logic [31:0] TMR_SPAN   = 32'd12;

    localparam logic [1:0] TMR_MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] TMR_MODE_PERIODIC = 2'd1;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_LOAD = 2'd1,
        TMR_CNT  = 2'd2,
        TMR_INT  = 2'd3
    } tmr_state_e;

    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_slot);
        return {pc[31:2], 2'b00} - (in_slot ? 32'd4 : 32'd0);
    endfunction

endpackage

// File: rtl/cp0_io_subsystem_timer_counter.sv
// Down-counting timer with CTRL/PRESET/COUNT registers and a maskable IRQ.
// Latency: register reads combinational, writes take effect next cycle.
// Backpressure: none; writes always accepted, COUNT is read-only.
module timer_counter
    import cp0_io_subsystem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] dout,
    output logic        irq_out
);

    logic [3:0]  ctrl;      // [3] IM, [2:1] mode, [0] enable
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq;
    tmr_state_e  state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= TMR_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TMR_IDLE: if (ctrl[0]) state_nxt = TMR_LOAD;
            TMR_LOAD: state_nxt = TMR_CNT;
            TMR_CNT: begin
                if (!ctrl[0])            state_nxt = TMR_IDLE;
                else if (count <= 32'd1) state_nxt = TMR_INT;
            end
            TMR_INT:  state_nxt = TMR_IDLE;
            default:  state_nxt = TMR_IDLE;
        endcase
    end

    // A CTRL write lands after the FSM updates so software always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= 4'b0;
            preset <= 32'b0;
            count  <= 32'b0;
            irq    <= 1'b0;
        end else begin
            case (state)
                TMR_LOAD: count <= preset;
                TMR_CNT: begin
                    if (ctrl[0]) begin
                        if (count > 32'd1) begin
                            count <= count - 32'd1;
                        end else begin
                            count <= 32'b0;
                            irq   <= 1'b1;
                        end
                    end
                end
                TMR_INT: begin
                    if (ctrl[2:1] == TMR_MODE_ONESHOT)       ctrl[0] <= 1'b0;
                    else if (ctrl[2:1] == TMR_MODE_PERIODIC) irq     <= 1'b0;
                end
                default: ;
            endcase
            if (we && reg_sel == TMR_CTRL) begin
                ctrl <= wdata[3:0];
                irq  <= 1'b0;
            end
            if (we && reg_sel == TMR_PRESET) preset <= wdata;
        end
    end

    always_comb begin
        dout = 32'b0;
        case (reg_sel)
            TMR_CTRL:   dout = {28'b0, ctrl};
            TMR_PRESET: dout = preset;
            TMR_COUNT:  dout = count;
            default:    dout = 32'b0;
        endcase
    end

    assign irq_out = ctrl[3] && irq;

endmodule

// File: rtl/cp0_io_subsystem.sv
// CP0 (SR/Cause/EPC/PRId, exception entry) plus address bridge to DM and two timers.
// Latency: int_req, read data and fault codes combinational; state updates next cycle.
// Backpressure: none; faulting or interrupted accesses are squashed, never stalled.
module cp0_io_subsystem
    import cp0_io_subsystem_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT = 32'h3000,
    parameter logic [31:0] T0_BASE  = 32'h7F00,
    parameter logic [31:0] T1_BASE  = 32'h7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_type,
    input  logic [1:0]  mem_mode,
    input  logic [31:0] wdata,
    input  logic [1:0]  cp0_op,
    input  logic [4:0]  cp0_addr,
    input  logic        bd,
    input  logic [31:0] epc_in,
    input  logic [4:0]  exc,
    output logic        int_req,
    output logic [31:0] epc_out,
    output logic [31:0] cp0_rdata,
    output logic [31:0] dev_rdata,
    output logic [4:0]  dev_exc,
    output logic [1:0]  dm_mode
);

    logic [5:0]  sr_im;
    logic        sr_exl, sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [5:0]  hw_int;
    logic        int_term;
    logic        t0_irq, t1_irq;
    logic [31:0] t0_dout, t1_dout;
    logic        t0_we, t1_we;
    logic [1:0]  t0_sel, t1_sel, tmr_sel;
    logic        in_dm, in_t0, in_t1, in_tmr;
    logic        is_rd, is_wr, misaligned, fault;

    assign hw_int   = {3'b000, interrupt, t1_irq, t0_irq};
    assign int_term = sr_ie && |(hw_int & sr_im);
    assign int_req  = !sr_exl && (int_term || exc != EXC_NONE);
    assign epc_out  = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'b0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'b0;
            cause_exc <= EXC_NONE;
            epc       <= 32'b0;
        end else begin
            cause_ip <= hw_int;
            if (int_req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_term ? EXC_INT : exc;
                cause_bd  <= bd;
                epc       <= epc_of(epc_in, bd);
            end else if (cp0_op == CP0_MTC0) begin
                if (cp0_addr == CP0_REG_SR) begin
                    sr_im  <= wdata[15:10];
                    sr_exl <= wdata[1];
                    sr_ie  <= wdata[0];
                end else if (cp0_addr == CP0_REG_EPC) begin
                    epc <= wdata;
                end
            end else if (cp0_op == CP0_ERET) begin
                sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'b0;
        case (cp0_addr)
            CP0_REG_SR:    cp0_rdata = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
            CP0_REG_CAUSE: cp0_rdata = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
            CP0_REG_EPC:   cp0_rdata = epc;
            CP0_REG_PRID:  cp0_rdata = PRID_VALUE;
            default:       cp0_rdata = 32'b0;
        endcase
    end

    assign in_dm  = mem_addr < DM_LIMIT;
    assign in_t0  = (mem_addr >= T0_BASE) && (mem_addr < T0_BASE + TMR_SPAN);
    assign in_t1  = (mem_addr >= T1_BASE) && (mem_addr < T1_BASE + TMR_SPAN);
    assign in_tmr = in_t0 || in_t1;
    assign is_rd  = mem_mode == MM_READ;
    assign is_wr  = mem_mode == MM_WRITE;

    // Timer bases are word aligned, so the register index is a 2-bit difference.
    assign t0_sel  = mem_addr[3:2] - T0_BASE[3:2];
    assign t1_sel  = mem_addr[3:2] - T1_BASE[3:2];
    assign tmr_sel = in_t0 ? t0_sel : t1_sel;

    assign misaligned = (mem_type == MT_WORD && mem_addr[1:0] != 2'b00) ||
                        (mem_type == MT_HALF && mem_addr[0]);
    assign fault = misaligned || !(in_dm || in_tmr) ||
                   (in_tmr && mem_type != MT_WORD) ||
                   (in_tmr && is_wr && tmr_sel == TMR_COUNT);

    assign dev_exc   = (is_rd && fault) ? EXC_ADEL :
                       (is_wr && fault) ? EXC_ADES : EXC_NONE;
    assign dm_mode   = (in_dm && !fault && (is_rd || is_wr)) ? mem_mode : MM_NONE;
    assign t0_we     = in_t0 && is_wr && !fault && !int_req;
    assign t1_we     = in_t1 && is_wr && !fault && !int_req;
    assign dev_rdata = in_t0 ? t0_dout : (in_t1 ? t1_dout : 32'b0);

    timer_counter u_timer0 (
        .clk     (clk),
        .reset   (reset),
        .we      (t0_we),
        .reg_sel (t0_sel),
        .wdata   (wdata),
        .dout    (t0_dout),
        .irq_out (t0_irq)
    );

    timer_counter u_timer1 (
        .clk     (clk),
        .reset   (reset),
        .we      (t1_we),
        .reg_sel (t1_sel),
        .wdata   (wdata),
        .dout    (t1_dout),
        .irq_out (t1_irq)
    );

endmodule

// File: tb/tb_cp0_io_subsystem.sv
// Self-checking bench for cp0_io_subsystem: bridge decode table plus CP0 and timer sequences.
module tb_cp0_io_subsystem;

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic [31:0] mem_addr;
    logic [1:0]  mem_type;
    logic [1:0]  mem_mode;
    logic [31:0] wdata;
    logic [1:0]  cp0_op;
    logic [4:0]  cp0_addr;
    logic        bd;
    logic [31:0] epc_in;
    logic [4:0]  exc;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] cp0_rdata;
    logic [31:0] dev_rdata;
    logic [4:0]  dev_exc;
    logic [1:0]  dm_mode;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cp0_io_subsystem dut (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .mem_addr  (mem_addr),
        .mem_type  (mem_type),
        .mem_mode  (mem_mode),
        .wdata     (wdata),
        .cp0_op    (cp0_op),
        .cp0_addr  (cp0_addr),
        .bd        (bd),
        .epc_in    (epc_in),
        .exc       (exc),
        .int_req   (int_req),
        .epc_out   (epc_out),
        .cp0_rdata (cp0_rdata),
        .dev_rdata (dev_rdata),
        .dev_exc   (dev_exc),
        .dm_mode   (dm_mode)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  mtype;
        logic [1:0]  mode;
        logic [4:0]  exp_exc;
        logic [1:0]  exp_dm;
    } bvec_t;

    typedef struct {
        logic [4:0] exc;
        logic [1:0] dm;
        int         idx;
    } bexp_t;

    bvec_t vecs[13];
    bexp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1; interrupt = 1'b0; mem_addr = 32'b0; mem_type = 2'd0; mem_mode = 2'd0;
        wdata = 32'b0; cp0_op = 2'd0; cp0_addr = 5'd0; bd = 1'b0; epc_in = 32'b0; exc = 5'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_addr = a; mem_type = 2'd0; mem_mode = 2'd2; wdata = d;
        @(posedge clk); #1;
        mem_mode = 2'd0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        cp0_op = 2'd2; cp0_addr = r; wdata = d;
        @(posedge clk); #1;
        cp0_op = 2'd0;
    endtask

    task automatic peek(input logic [4:0] r, output logic [31:0] v);
        cp0_addr = r;
        #1 v = cp0_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic        found;
        logic        prev;
        int          last_rise, pulses, run_len;

        vecs[0]  = '{32'h0000_7F00, 2'd1, 2'd1, 5'd4, 2'd0}; // lh timer
        vecs[1]  = '{32'h0000_7F08, 2'd0, 2'd2, 5'd5, 2'd0}; // sw COUNT
        vecs[2]  = '{32'h0000_3000, 2'd0, 2'd1, 5'd4, 2'd0}; // lw just past DM
        vecs[3]  = '{32'h0000_0003, 2'd2, 2'd2, 5'd0, 2'd2}; // sb DM
        vecs[4]  = '{32'h0000_0100, 2'd0, 2'd1, 5'd0, 2'd1}; // lw DM
        vecs[5]  = '{32'h0000_0102, 2'd0, 2'd1, 5'd4, 2'd0}; // lw misaligned
        vecs[6]  = '{32'h0000_0101, 2'd1, 2'd2, 5'd5, 2'd0}; // sh misaligned
        vecs[7]  = '{32'h0000_2FFE, 2'd1, 2'd1, 5'd0, 2'd1}; // lh last DM half
        vecs[8]  = '{32'h0000_7F0C, 2'd0, 2'd1, 5'd4, 2'd0}; // lw past timer0
        vecs[9]  = '{32'h0000_7F08, 2'd0, 2'd1, 5'd0, 2'd0}; // lw COUNT ok
        vecs[10] = '{32'h0000_3000, 2'd0, 2'd0, 5'd0, 2'd0}; // mode none
        vecs[11] = '{32'h0000_7F14, 2'd0, 2'd2, 5'd0, 2'd0}; // sw timer1 PRESET
        vecs[12] = '{32'h0000_7F1C, 2'd0, 2'd2, 5'd5, 2'd0}; // sw past timer1

        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst.int_req", {31'b0, int_req}, 32'd0);
        chk("rst.epc_out", epc_out, 32'd0);
        peek(5'd12, v); chk("rst.sr", v, 32'd0);
        peek(5'd13, v); chk("rst.cause", v, 32'd0);
        peek(5'd15, v); chk("rst.prid", v, 32'h7);
        @(posedge clk); #1;

        // MTC0 corners: Cause/PRId writes ignored, EPC visible next cycle
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'hFFFF_FFFF);
        cp0_op = 2'd2; cp0_addr = 5'd14; wdata = 32'h1234_5678;
        @(negedge clk);
        chk("mtc0.epc_same_cycle", epc_out, 32'd0);
        @(posedge clk); #1;
        cp0_op = 2'd0;
        chk("mtc0.epc_next_cycle", epc_out, 32'h1234_5678);
        mtc0(5'd12, 32'hFFFF_FFFF);
        @(negedge clk);
        peek(5'd12, v); chk("mtc0.sr_mask", v, 32'h0000_FC03);
        peek(5'd13, v); chk("mtc0.cause_ignored", v, 32'd0);
        peek(5'd15, v); chk("mtc0.prid_ignored", v, 32'h7);
        peek(5'd3, v);  chk("mfc0.unknown", v, 32'd0);
        peek(5'd14, v); chk("mfc0.epc", v, 32'h1234_5678);

        // Bridge decode table, scoreboarded
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            bexp_t e;
            mem_addr = vecs[i].addr; mem_type = vecs[i].mtype; mem_mode = vecs[i].mode;
            wdata = 32'h5;
            sb.push_back('{vecs[i].exp_exc, vecs[i].exp_dm, i});
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("bridge[%0d].dev_exc", e.idx), {27'b0, dev_exc}, {27'b0, e.exc});
            chk($sformatf("bridge[%0d].dm_mode", e.idx), {30'b0, dm_mode}, {30'b0, e.dm});
            @(posedge clk); #1;
        end
        mem_mode = 2'd0;

        // Exception entry in a delay slot, then ERET
        reset_dut();
        exc = 5'd12; bd = 1'b1; epc_in = 32'h3010;
        @(negedge clk);
        chk("exc.int_req", {31'b0, int_req}, 32'd1);
        @(posedge clk); #1;
        exc = 5'd0; bd = 1'b0;
        chk("exc.epc", epc_out, 32'h300C);
        @(negedge clk);
        peek(5'd13, v); chk("exc.cause", v, 32'h8000_0030);
        peek(5'd12, v); chk("exc.sr_exl", v, 32'h2);
        @(posedge clk); #1;
        exc = 5'd10;
        @(negedge clk);
        chk("exl.blocks_exc", {31'b0, int_req}, 32'd0);
        @(posedge clk); #1;
        cp0_op = 2'd3;
        @(posedge clk); #1;
        cp0_op = 2'd0;
        @(negedge clk);
        chk("eret.reenables", {31'b0, int_req}, 32'd1);
        exc = 5'd0;
        peek(5'd12, v); chk("eret.sr", v, 32'd0);
        @(posedge clk); #1;

        // Timer0 interrupt taken through SR.IM[10]/IE
        reset_dut();
        mtc0(5'd12, 32'h0000_0401);
        bus_write(32'h7F04, 32'd1);
        bus_write(32'h7F00, 32'hB);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (int_req) found = 1'b1;
        end
        chk("tint.int_req", {31'b0, found}, 32'd1);
        @(negedge clk);
        peek(5'd13, v);
        chk("tint.exccode", {27'b0, v[6:2]}, 32'd0);
        chk("tint.ip10", {31'b0, v[10]}, 32'd1);
        peek(5'd12, v); chk("tint.sr", v, 32'h0000_0403);
        chk("tint.exl_masks", {31'b0, int_req}, 32'd0);
        @(posedge clk); #1;

        // Timer0 one-shot: COUNT 3,2,1,0 then IRQ held and Enable cleared
        reset_dut();
        bus_write(32'h7F04, 32'd3);
        bus_write(32'h7F00, 32'h9);
        mem_addr = 32'h7F08;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dev_rdata == 32'd3) found = 1'b1;
        end
        chk("t0.count3", dev_rdata, 32'd3);
        @(negedge clk); chk("t0.count2", dev_rdata, 32'd2);
        @(negedge clk); chk("t0.count1", dev_rdata, 32'd1);
        @(negedge clk); chk("t0.count0", dev_rdata, 32'd0);
        @(negedge clk);
        peek(5'd13, v); chk("t0.irq_ip", {31'b0, v[10]}, 32'd1);
        mem_addr = 32'h7F00;
        #1 chk("t0.ctrl_enable_clr", dev_rdata, 32'h8);
        repeat (3) @(negedge clk);
        peek(5'd13, v); chk("t0.irq_held", {31'b0, v[10]}, 32'd1);
        @(posedge clk); #1;
        bus_write(32'h7F00, 32'h8);
        repeat (2) @(negedge clk);
        peek(5'd13, v); chk("t0.ctrl_write_clears", {31'b0, v[10]}, 32'd0);
        @(posedge clk); #1;

        // Timer1 periodic: one-cycle IRQ every PRESET+3 cycles
        reset_dut();
        bus_write(32'h7F14, 32'd2);
        bus_write(32'h7F10, 32'hB);
        prev = 1'b0; last_rise = -1; pulses = 0; run_len = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            peek(5'd13, v);
            if (v[11]) begin
                if (!prev) begin
                    if (last_rise >= 0) chk("t1.period", c - last_rise, 32'd5);
                    last_rise = c;
                    pulses++;
                end
                run_len++;
            end else if (prev) begin
                chk("t1.width", run_len, 32'd1);
                run_len = 0;
            end
            prev = v[11];
        end
        chk("t1.pulse_count", {31'b0, pulses >= 3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
